// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the even-parity bit (11-bit frame instead of 10).
module uart_tx #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p_data,
  input  logic       data_valid,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [4:0] PS_LAST = 5'(PRESCALE - 1);

  logic [2:0] state;
  logic [4:0] ps_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       bit_end;

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed during DATA, so parity is captured at acceptance.
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (state == IDLE && data_valid) begin
      parity_bit <= ^p_data;
    end
  end
`endif

  assign bit_end = (ps_cnt == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ps_cnt    <= 5'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          ps_cnt <= 5'd0;
          if (data_valid) begin
            shift_reg <= p_data;
            busy      <= 1'b1;
            tx_out    <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            ps_cnt  <= 5'd0;
            bit_idx <= 3'd0;
            tx_out  <= shift_reg[0];
            state   <= DATA;
          end else begin
            ps_cnt <= ps_cnt + 5'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            ps_cnt    <= 5'd0;
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_out <= parity_bit;
              state  <= PARITY;
`else
              tx_out <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              // Next bit is presented from the register so the line never glitches.
              tx_out <= shift_reg[1];
            end
          end else begin
            ps_cnt <= ps_cnt + 5'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            ps_cnt <= 5'd0;
            tx_out <= 1'b1;
            state  <= STOP;
          end else begin
            ps_cnt <= ps_cnt + 5'd1;
          end
        end
`endif

        STOP: begin
          tx_out <= 1'b1;
          if (bit_end) begin
            ps_cnt  <= 5'd0;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            ps_cnt <= ps_cnt + 5'd1;
          end
        end

        default: begin
          state  <= IDLE;
          ps_cnt <= 5'd0;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - Bench for uart_tx at PRESCALE 8 and 16 against a bit-level line model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pd8, pd16;
  logic       dv8, dv16;
  logic       tx8, busy8, done8;
  logic       tx16, busy16, done16;

  int errors = 0;
  int checks = 0;
  bit sel = 1'b0;

  logic tx_s, busy_s, done_s;

  always #5 clk = ~clk;

  uart_tx #(.PRESCALE(8)) u_dut8 (
    .clk(clk), .rst(rst), .p_data(pd8), .data_valid(dv8),
    .tx_out(tx8), .busy(busy8), .tx_done(done8)
  );

  uart_tx #(.PRESCALE(16)) u_dut16 (
    .clk(clk), .rst(rst), .p_data(pd16), .data_valid(dv16),
    .tx_out(tx16), .busy(busy16), .tx_done(done16)
  );

  always_comb begin
    tx_s   = sel ? tx16   : tx8;
    busy_s = sel ? busy16 : busy8;
    done_s = sel ? done16 : done8;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  function automatic int cur_p();
    return sel ? 16 : 8;
  endfunction

  // Frame position i: 0 start, 1..8 data LSB first, then parity (if any), then stop.
  function automatic logic exp_bit(logic [7:0] d, logic par, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (NBITS == 11 && i == 9) return par;
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d);
    if (sel) begin
      dv16 = v; pd16 = d;
    end else begin
      dv8 = v; pd8 = d;
    end
  endtask

  task automatic idle_check(string name, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", name, i), {29'd0, tx_s, busy_s, done_s}, 32'b100);
    end
  endtask

  // Called at a negedge; acceptance happens on the following posedge (edge k).
  // Returns at the negedge after edge k+F, leaving data_valid as hold requests.
  task automatic run_frame(input logic [7:0] data, input logic par, input bit hold,
                           input logic [7:0] next_pd, input int inject_at,
                           output logic [10:0] line);
    int p;
    int f;
    p = cur_p();
    f = NBITS * p;
    line = '1;
    drive(1'b1, data);
    @(posedge clk);
    @(negedge clk);
    drive(hold, next_pd);
    for (int j = 0; j < f; j++) begin
      if (j > 0) @(negedge clk);
      if (inject_at >= 0 && j == inject_at) drive(1'b1, 8'hFF);
      if (inject_at >= 0 && j == inject_at + 1) drive(1'b0, 8'hFF);
      chk($sformatf("line d=%02h t=%0d", data, j), {29'd0, tx_s, busy_s, done_s},
          {29'd0, exp_bit(data, par, j / p), 1'b1, 1'b0});
      if (j % p == p / 2) line[j / p] = tx_s;
    end
    @(negedge clk);
    chk($sformatf("done d=%02h", data), {29'd0, tx_s, busy_s, done_s}, 32'b101);
  endtask

  initial begin
    logic [10:0] line;
    logic [7:0]  b;
    logic [9:0]  a5_line10;
    logic [10:0] a5_line11;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h81, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'hFE, 1'b1};
    a5_line10 = 10'b1101001010;
    a5_line11 = 11'b10101001010;

    rst = 1'b1; dv8 = 1'b1; dv16 = 1'b1; pd8 = 8'h5A; pd16 = 8'h5A;

    // Reset held with data_valid asserted: line idle throughout.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("reset8[%0d]", i), {29'd0, tx8, busy8, done8}, 32'b100);
      chk($sformatf("reset16[%0d]", i), {29'd0, tx16, busy16, done16}, 32'b100);
    end
    rst = 1'b0; dv8 = 1'b0; dv16 = 1'b0;
    sel = 1'b0;
    idle_check("post_reset_idle", 20);

    // Table vectors at PRESCALE 8, with p_data scrambled after acceptance.
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].data, vecs[v].par, 1'b0, 8'($urandom), -1, line);
      chk($sformatf("decode %02h", vecs[v].data), {24'd0, line[8:1]}, {24'd0, vecs[v].data});
      if (v == 0) begin
        if (NBITS == 11) chk("a5_line", {21'd0, line}, {21'd0, a5_line11});
        else chk("a5_line", {22'd0, line[9:0]}, {22'd0, a5_line10});
      end
      if (v == 3) chk("loopback_3c", {24'd0, line[8:1]}, 32'h3C);
    end

    // Busy-ignore: 0xFF requested mid-frame must not produce a second frame.
    run_frame(8'h00, 1'b0, 1'b0, 8'h00, 20, line);
    chk("busy_ignore_decode", {24'd0, line[8:1]}, 32'h00);
    idle_check("no_second_frame", 16);

    // Randomized bytes against the model.
    for (int r = 0; r < 16; r++) begin
      b = 8'($urandom);
      run_frame(b, 1'($countones(b) % 2), 1'b0, 8'($urandom), -1, line);
      chk($sformatf("rand_decode %02h", b), {24'd0, line[8:1]}, {24'd0, b});
    end
    idle_check("idle_after_rand", 4);

    // Back-to-back at PRESCALE 16: one idle-high clock, second start at k+F+1.
    sel = 1'b1;
    run_frame(8'h55, 1'b0, 1'b1, 8'hAA, -1, line);
    chk("b2b_first", {24'd0, line[8:1]}, 32'h55);
    run_frame(8'hAA, 1'b0, 1'b0, 8'h00, -1, line);
    chk("b2b_second", {24'd0, line[8:1]}, 32'hAA);
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      run_frame(b, 1'($countones(b) % 2), 1'b0, 8'($urandom), -1, line);
      chk($sformatf("rand16_decode %02h", b), {24'd0, line[8:1]}, {24'd0, b});
    end
    idle_check("idle16", 4);

    // Mid-frame reset at k+35 on PRESCALE 8.
    sel = 1'b0;
    drive(1'b1, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00);
    chk("abort_t0", {29'd0, tx_s, busy_s, done_s}, 32'b010);
    for (int j = 1; j < 35; j++) begin
      @(negedge clk);
      chk($sformatf("abort_line t=%0d", j), {29'd0, tx_s, busy_s, done_s},
          {29'd0, exp_bit(8'h3C, 1'b0, j / 8), 1'b1, 1'b0});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_reset", {29'd0, tx_s, busy_s, done_s}, 32'b100);
    rst = 1'b0;
    idle_check("abort_idle", 16);

    // Recovery after abort.
    run_frame(8'hC3, 1'b0, 1'b0, 8'h00, -1, line);
    chk("recover_decode", {24'd0, line[8:1]}, 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the upstream partner of the receive path: it takes a parallel byte and drives the serial line that feeds the receiver's `RX_IN`. Bit period is PRESCALE system clocks, matching the receiver's oversampling edge counter, so a transmitter and receiver on the same `clk` interoperate with no further configuration. Frames are start bit (0), 8 data bits LSB first, optional even parity, and one stop bit (1).

## Interface
- `PRESCALE`, 8: clocks per bit. Legal range 4..32. The prescale counter is 5 bits wide.
- `clk`  in  1: system clock (PLL output); all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `p_data`  in  8: byte to send. Sampled only on the accepting edge.
- `data_valid`  in  1: request to send `p_data`. Accepted only when `busy`=0.
- `tx_out`  out  1: serial line. Idle level is 1.
- `busy`  out  1: high from the accepting edge through the last stop-bit clock.
- `tx_done`  out  1: single-cycle pulse on the edge that ends the stop bit.

## Operation
- Reset values:
  - `tx_out`=1, `busy`=0, `tx_done`=0.
  - State IDLE; prescale counter, bit index and data shift register all 0.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx_out`=1.
  - If `data_valid`=1 on an edge: latch `p_data`, set `busy`=1, clear the prescale counter, go to START.
- START: `tx_out`=0 for PRESCALE clocks, then go to DATA with bit index 0.
- DATA:
  - `tx_out`=shift register bit 0 for PRESCALE clocks.
  - Then shift right and increment the bit index.
  - After index 7 completes, go to PARITY (macro on) or STOP.
- PARITY: `tx_out`= XOR of the latched byte (even parity) for PRESCALE clocks, then go to STOP.
- STOP:
  - `tx_out`=1 for PRESCALE clocks.
  - On the final clock edge: go to IDLE, `busy`→0, `tx_done`=1 for one cycle.
- Prescale counter runs 0..PRESCALE-1 and wraps to 0 at each bit boundary. The bit index wraps 7→0 only on the DATA exit.
- `data_valid` while `busy`=1 is ignored. No queueing, no error flag. Changes to `p_data` after acceptance have no effect.
- `tx_out` is driven from a register, never combinationally, so the line is glitch-free.
- Reset mid-frame:
  - On the reset edge, `tx_out` returns to 1 and `busy`/`tx_done` go to 0.
  - The partial frame is abandoned. A receiver sees either a truncated frame or a framing error, never a corrupted "valid" one.
- Reset and `data_valid` on the same edge: reset wins and the byte is not accepted.

## Timing
- Accepting edge k (IDLE, `data_valid`=1): `tx_out`=0 and `busy`=1 visible after edge k.
- Data bit n occupies clocks k+(1+n)·PRESCALE .. k+(2+n)·PRESCALE−1.
- Frame length F = 10·PRESCALE clocks (macro off) or 11·PRESCALE (macro on).
- At edge k+F: state is IDLE, `busy`=0, `tx_done`=1 for that one cycle.
- Earliest next acceptance is edge k+F+1, so sustained throughput is one byte per F+1 clocks. `tx_out` stays 1 for at least that one idle clock.
- `tx_done` and `busy` fall together. `tx_done` never coincides with an acceptance.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in; frame is 11 bits.
  - Parity bit = ^p_data (even parity: total count of 1s across the data and parity bits is even).
- Not defined:
  - PARITY state and XOR logic absent; DATA goes directly to STOP; frame is 10 bits.
  - Parity in the receiver must be disabled to match.

## Test plan
- Reset: hold `rst`=1 for 3 clocks with `data_valid`=1 → `tx_out`=1, `busy`=0, `tx_done`=0 throughout. No frame starts after reset releases until a fresh `data_valid`.
- Single byte, PRESCALE=8, macro off: accept 0xA5 at edge k.
  - `tx_out` bits (8 clocks each) = 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 80 clocks; `tx_done` pulse at k+80.
- Parity, PRESCALE=8, macro on:
  - 0x07 → parity bit 1; frame 0,1,1,1,0,0,0,0,0,1,1; `tx_done` at k+88.
  - 0x03 → parity bit 0.
- Busy-ignore: pulse `data_valid` with 0xFF at k+20 while sending 0x00 → the line carries only 0x00. No second frame follows.
- Back-to-back, PRESCALE=16: hold `data_valid`=1 with 0x55 then 0xAA → second start bit begins at k+161. Exactly one idle-high clock between frames.
- Loopback and mid-frame reset: connect `tx_out` to the receiver `RX_IN` at PRESCALE=8 and send 0x3C → receiver `p_data`=0x3C. Assert `rst` at k+35 → `tx_out`=1 on the next edge and `busy`=0.
